myspi_tx: RTL and testbench
===========================

MYSPI_TX -- requirements
Module: myspi_tx

Interface
REQ-001 Parameter FRAME_W, default 11: frame length in bits.
REQ-002 Parameter IDLE_WORD, default all-ones (FRAME_W bits): fill frame sent when no data is queued.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  FRAME_W  word to transmit.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 tx  output  1  serial line; the receiver samples it on the falling edge of clk.
REQ-009 count  output  6  data frames started, modulo 64.
REQ-010 underrun  output  1  one-cycle pulse when IDLE_WORD is loaded because the FIFO is empty.

Function
REQ-011 Transfer on in_valid && in_ready; words held in a 2-entry FIFO, in order.
REQ-012 in_ready = FIFO not full; depends only on state, never on in_valid.
REQ-013 Push when full is impossible by construction; no combinational push-through to the shifter.
REQ-014 Frame slots run continuously, back-to-back, with no gaps, start bits or stop bits.
REQ-015 Slot position bit_idx counts 0..FRAME_W-1 and wraps to 0.
REQ-016 Shift register sh is FRAME_W bits; tx is sh[0], driven straight from the register.
REQ-017 Bit order is LSB first: word bit k appears on tx during slot cycle k.
REQ-018 Each rising edge with bit_idx < FRAME_W-1: sh shifts right by one, bit_idx increments.
REQ-019 Each rising edge with bit_idx == FRAME_W-1: bit_idx goes to 0, and sh loads the next frame.
REQ-020 Next frame is the FIFO head if the FIFO is non-empty (pop, count +1); otherwise IDLE_WORD.
REQ-021 When IDLE_WORD is loaded: count is unchanged and underrun pulses for one cycle.
REQ-022 count wraps from 63 to 0.
REQ-023 A push and a pop in the same cycle are both honoured; occupancy is unchanged.
REQ-024 A word pushed into an empty FIFO on the load edge is not visible to that load; it goes out in the following slot.
REQ-025 Latency from accept to first bit on tx is 1 to FRAME_W+... cycles: the word starts at the next load edge, after any queued word.

Reset
REQ-026 On rst high at a rising edge, the block is set as follows:
- bit_idx = 0
- sh = IDLE_WORD (so tx = IDLE_WORD[0])
- FIFO empty, so in_ready = 1
- count = 0
- underrun = 0
REQ-027 rst asserted mid-frame aborts the frame; queued words are discarded and not transmitted.
REQ-028 The first slot after reset release is always an IDLE_WORD frame.
REQ-029 The load at the end of that first slot follows REQ-020 and REQ-021; an empty FIFO there produces an underrun pulse.

Structure
REQ-030 Package myspi_pkg holds FRAME_W, the count width (6) and the default IDLE_WORD; the same package is shared with the receiver.
REQ-031 The FIFO is sub-module myspi_fifo2, a 2-entry FIFO with valid/ready on the write side and a pop strobe on the read side.
REQ-032 The shifter, slot counter and frame counter live in myspi_tx.

Verification
REQ-033 Reset, no input for 33 cycles: tx constant 1; underrun pulses on the load edges at cycles 11, 22 and 33; count stays 0.
REQ-034 Push 11'h2A5 during the first slot: the next slot puts LSB first 1,0,1,0,0,1,0,1,0,1,0 on tx; count becomes 1 on that load edge; no underrun on that edge.
REQ-035 Hold in_valid high with words 1..5:
- in_ready drops after two accepts and re-asserts one cycle after each pop.
- Frames appear in order with no idle frame between them.
- count reaches 5.
REQ-036 Push exactly on the load edge with the FIFO empty: an IDLE frame is sent first with an underrun pulse; the word goes out in the next slot.
REQ-037 Assert rst at bit_idx 5 with two words queued: tx returns to 1; count = 0; in_ready = 1; neither queued word is ever transmitted.
REQ-038 Stream 64 data frames: count wraps to 0; a loopback to the receiver decodes every word bit-exact.

Source files
------------

// File: rtl/myspi_pkg.sv
// Shared constants for the myspi serial link, used by both the transmitter and the receiver.
package myspi_pkg;
    localparam int FRAME_W = 11;
    localparam int COUNT_W = 6;
    localparam logic [FRAME_W-1:0] IDLE_WORD = '1;
endpackage

// File: rtl/myspi_if.sv
// Word-input handshake and serial-side outputs of the myspi transmitter.
interface myspi_if #(
    parameter int FRAME_W = myspi_pkg::FRAME_W
);
    import myspi_pkg::*;

    localparam int IDX_W = $clog2(FRAME_W);

    // A word moves on every rising edge where in_valid && in_ready; in_ready never looks at in_valid.
    logic [FRAME_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               tx;
    logic [COUNT_W-1:0] count;
    logic               underrun;
    logic [IDX_W-1:0]   bit_idx;

    modport master (
        output in_data, in_valid,
        input  in_ready, tx, count, underrun, bit_idx
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, tx, count, underrun, bit_idx
    );
endinterface

// File: rtl/myspi_fifo2.sv
// Two-entry in-order FIFO: valid/ready on the write side, pop strobe on the read side.
module myspi_fifo2 #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         pop
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   used;
    logic         do_push;
    logic         do_pop;

    assign wr_ready = (used != 2'd2);
    assign rd_valid = (used != 2'd0);
    assign rd_data  = mem[rd_ptr];
    assign do_push  = wr_valid && wr_ready;
    assign do_pop   = pop && rd_valid;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            used   <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            used <= used + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/myspi_tx.sv
// Continuous back-to-back LSB-first frame transmitter fed by a 2-entry FIFO.
module myspi_tx #(
    parameter int                 FRAME_W   = myspi_pkg::FRAME_W,
    parameter logic [FRAME_W-1:0] IDLE_WORD = {FRAME_W{1'b1}}
) (
    input logic   clk,
    input logic   rst,
    myspi_if.slave bus
);
    import myspi_pkg::*;

    localparam int               IDX_W = $clog2(FRAME_W);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] sh;
    logic [IDX_W-1:0]   bit_idx;
    logic [COUNT_W-1:0] count;
    logic               underrun;
    logic [FRAME_W-1:0] head;
    logic               head_valid;
    logic               load;
    logic               pop;

    assign load = (bit_idx == LAST);
    assign pop  = load && head_valid;

    myspi_fifo2 #(.W(FRAME_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (bus.in_data),
        .wr_valid (bus.in_valid),
        .wr_ready (bus.in_ready),
        .rd_data  (head),
        .rd_valid (head_valid),
        .pop      (pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx  <= '0;
            sh       <= IDLE_WORD;
            count    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (load) begin
                bit_idx <= '0;
                // A word arriving on this same edge is not yet at the FIFO head.
                if (head_valid) begin
                    sh    <= head;
                    count <= count + 1'b1;
                end else begin
                    sh       <= IDLE_WORD;
                    underrun <= 1'b1;
                end
            end else begin
                bit_idx <= bit_idx + 1'b1;
                sh      <= {1'b0, sh[FRAME_W-1:1]};
            end
        end
    end

    assign bus.tx       = sh[0];
    assign bus.count    = count;
    assign bus.underrun = underrun;
    assign bus.bit_idx  = bit_idx;
endmodule

// File: tb/tb_myspi_tx.sv
// Randomized bench for myspi_tx with a frame-level model and a scoreboard of accepted words.
module tb_myspi_tx;
    import myspi_pkg::*;

    localparam int FW = FRAME_W;
    localparam int PW = $clog2(FW);

    logic clk = 1'b0;
    logic rst = 1'b1;

    myspi_if #(.FRAME_W(FW)) bus ();

    myspi_tx #(.FRAME_W(FW), .IDLE_WORD(IDLE_WORD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Rising edges since reset release; slot boundaries fall on multiples of FW.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    logic [FW-1:0] exp_q[$];
    int            stamp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: the frame on the line is chosen at each slot boundary from the accepted-word queue.
    logic [FW-1:0]      cur;
    logic [FW-1:0]      rx;
    logic [COUNT_W-1:0] exp_count;
    logic               exp_under;
    logic [PW-1:0]      p;

    initial begin
        cur       = IDLE_WORD;
        rx        = '0;
        exp_count = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            p         = PW'(cyc % FW);
            exp_under = 1'b0;
            if (cyc == 0) begin
                exp_q.delete();
                stamp_q.delete();
                cur       = IDLE_WORD;
                exp_count = '0;
            end else if (p == 0) begin
                if (exp_q.size() > 0 && stamp_q[0] < cyc) begin
                    cur = exp_q.pop_front();
                    void'(stamp_q.pop_front());
                    exp_count = exp_count + 1'b1;
                end else begin
                    cur       = IDLE_WORD;
                    exp_under = 1'b1;
                end
            end
            rx[p] = bus.tx;
            check("tx", 32'(bus.tx), 32'(cur[p]));
            check("underrun", 32'(bus.underrun), 32'(exp_under));
            check("count", 32'(bus.count), 32'(exp_count));
            check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
            if (int'(p) == FW - 1) begin
                check("rx_frame", 32'(rx), 32'(cur));
            end
        end
    end

    // Called just after a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [FW-1:0] w);
        int tries;
        bit acc;
        int stamp;
        tries = 0;
        acc   = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        while (!acc) begin
            acc   = bus.in_ready;
            stamp = cyc + 1;
            @(negedge clk);
            if (acc) begin
                exp_q.push_back(w);
                stamp_q.push_back(stamp);
            end else begin
                tries++;
                if (tries > 100) begin
                    check("send_timeout", 32'd0, 32'd1);
                    break;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle line after reset: underrun on every boundary, count stays 0.
        idle(34);

        // Single word pushed during the first slot.
        do_reset(2);
        idle(3);
        send(FW'(11'h2A5));
        idle(30);

        // Back-to-back burst with in_valid held high.
        for (int i = 1; i <= 5; i++) begin
            send(FW'(i));
        end
        idle(80);

        // Push landing exactly on a load edge with the FIFO empty.
        while ((cyc + 1) % FW != 0) @(negedge clk);
        send(FW'($urandom));
        idle(30);

        // Reset mid-frame with two words queued.
        while (cyc % FW != 1) @(negedge clk);
        send(FW'($urandom));
        send(FW'($urandom));
        bus.in_valid = 1'b0;
        while (cyc % FW != 5) @(negedge clk);
        do_reset(2);
        idle(30);

        // Long stream so count wraps, then random gaps.
        repeat (64) send(FW'($urandom));
        repeat (30) begin
            send(FW'($urandom));
            idle($urandom_range(0, 15));
        end
        idle(40);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
